// File: rtl/pipe_ctrl_pkg.sv
// Shared bus types, stall encodings, exception codes and FSM states for the
// pipeline controller.
package pipe_ctrl_pkg;

  localparam int REG_BUS_W   = 32;
  localparam int INST_ADDR_W = 32;
  localparam int STALL_W     = 6;

  typedef logic [REG_BUS_W-1:0]   RegBus;
  typedef logic [INST_ADDR_W-1:0] InstAddrBus;
  typedef logic [STALL_W-1:0]     StallVec;

  // Bit order is {wb,mem,ex,id,if,pc}; each stage holds itself and everything upstream.
  localparam StallVec STALL_MEM  = 6'b011111;
  localparam StallVec STALL_EX   = 6'b001111;
  localparam StallVec STALL_ID   = 6'b000111;
  localparam StallVec STALL_IF   = 6'b000011;
  localparam StallVec STALL_PC   = 6'b000001;
  localparam StallVec STALL_NONE = 6'b000000;

  localparam RegBus EXC_ERET = 32'h0000_000E;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_EXC_PEND   = 2'd1,
    ST_FLUSH_HOLD = 2'd2,
    ST_IF_DRAIN   = 2'd3
  } PipeState;

  function automatic StallVec stallPriority(input logic reqMem,
                                            input logic reqEx,
                                            input logic reqId,
                                            input logic reqIf);
    StallVec result;
    result = STALL_NONE;
    if (reqMem)     result = STALL_MEM;
    else if (reqEx) result = STALL_EX;
    else if (reqId) result = STALL_ID;
    else if (reqIf) result = STALL_IF;
    return result;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles and emits a registered one-cycle pulse
// when the run length reaches the configured limit.
module stall_watchdog #(
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stalled,
  input  logic i_flush,
  output logic o_timeout
);

  localparam logic [WDOG_W-1:0] LIMIT_LAST = WDOG_LIMIT - 1'b1;

  logic [WDOG_W-1:0] r_cnt;
  logic              r_timeout;

  // The compare is >= so the counter can never run past the limit and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (i_flush || !i_stalled) begin
        r_cnt <= '0;
      end else if (r_cnt >= LIMIT_LAST) begin
        r_cnt     <= '0;
        r_timeout <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, turns MEM-stage exceptions
// into a single-cycle flush/redirect, and watches for stalls that never end.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter InstAddrBus        EXC_VECTOR = 32'h0000_0020,
  parameter int                WDOG_W     = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_if,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   stallreq_mem,
  input  logic [REG_BUS_W-1:0]   excepttype_i,
  input  logic [INST_ADDR_W-1:0] cp0_epc_i,
  output logic [STALL_W-1:0]     stall_o,
  output logic                   flush_o,
  output logic [INST_ADDR_W-1:0] new_pc_o,
  output logic                   exc_taken_o,
  output logic                   wdog_timeout_o,
  output logic [1:0]             state_o
);

  PipeState   r_state;
  InstAddrBus r_pendVec;
  logic       r_excTaken;

  PipeState   w_nextState;
  StallVec    w_reqStall;
  StallVec    w_stall;
  logic       w_flush;
  InstAddrBus w_newPc;
  InstAddrBus w_vector;
  logic       w_hasExc;
  logic       w_latchPend;
  logic       w_timeout;

  assign w_reqStall = stallPriority(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
  assign w_hasExc   = (excepttype_i != '0);
  assign w_vector   = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pendVec  <= '0;
      r_excTaken <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_excTaken <= w_flush;
      if (w_latchPend) begin
        r_pendVec <= w_vector;
      end
    end
  end

  // Outside RUN the exception input belongs to an instruction already being
  // flushed, so only RUN ever looks at excepttype_i.
  always_comb begin
    w_nextState = r_state;
    w_stall     = STALL_NONE;
    w_flush     = 1'b0;
    w_newPc     = '0;
    w_latchPend = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_hasExc && stallreq_mem) begin
          w_stall     = STALL_MEM;
          w_latchPend = 1'b1;
          w_nextState = ST_EXC_PEND;
        end else if (w_hasExc) begin
          w_flush     = 1'b1;
          w_newPc     = w_vector;
          w_nextState = stallreq_if ? ST_IF_DRAIN : ST_FLUSH_HOLD;
        end else begin
          w_stall = w_reqStall;
        end
      end
      ST_EXC_PEND: begin
        if (stallreq_mem) begin
          w_stall = STALL_MEM;
        end else begin
          w_flush     = 1'b1;
          w_newPc     = r_pendVec;
          w_nextState = stallreq_if ? ST_IF_DRAIN : ST_FLUSH_HOLD;
        end
      end
      ST_FLUSH_HOLD: begin
        w_stall     = w_reqStall;
        w_nextState = ST_RUN;
      end
      ST_IF_DRAIN: begin
        // The last drain cycle holds only the PC while the stale word is dropped.
        if (stallreq_if) begin
          w_stall = STALL_IF;
        end else begin
          w_stall     = STALL_PC;
          w_nextState = ST_RUN;
        end
      end
      default: begin
        w_nextState = ST_RUN;
      end
    endcase
    if (rst) begin
      w_stall = STALL_NONE;
      w_flush = 1'b0;
      w_newPc = '0;
    end
  end

  stall_watchdog #(
    .WDOG_W     (WDOG_W),
    .WDOG_LIMIT (WDOG_LIMIT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_stalled (|w_stall),
    .i_flush   (w_flush),
    .o_timeout (w_timeout)
  );

  assign stall_o        = w_stall;
  assign flush_o        = w_flush;
  assign new_pc_o       = w_newPc;
  assign exc_taken_o    = r_excTaken;
  assign wdog_timeout_o = w_timeout;
  assign state_o        = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stimulus pushes per-cycle expectations into a
// queue, and an independent monitor pops and compares them on the falling edge.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] newPc;
    logic        excTaken;
    logic        wdog;
    logic [1:0]  state;
  } ExpectT;

  logic        clk;
  logic        rst;
  logic        stallreqIf;
  logic        stallreqId;
  logic        stallreqEx;
  logic        stallreqMem;
  logic [31:0] excepttype;
  logic [31:0] cp0Epc;
  logic [5:0]  stallOut;
  logic        flushOut;
  logic [31:0] newPcOut;
  logic        excTakenOut;
  logic        wdogOut;
  logic [1:0]  stateOut;

  ExpectT expQ[$];
  string  nameQ[$];
  int     checks = 0;
  int     errors = 0;

  pipe_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .WDOG_W     (16),
    .WDOG_LIMIT (16'd8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if    (stallreqIf),
    .stallreq_id    (stallreqId),
    .stallreq_ex    (stallreqEx),
    .stallreq_mem   (stallreqMem),
    .excepttype_i   (excepttype),
    .cp0_epc_i      (cp0Epc),
    .stall_o        (stallOut),
    .flush_o        (flushOut),
    .new_pc_o       (newPcOut),
    .exc_taken_o    (excTakenOut),
    .wdog_timeout_o (wdogOut),
    .state_o        (stateOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue what the DUT must show during that cycle.
  task automatic applyStimulus(input logic r, input logic mem, input logic ex,
                               input logic id, input logic ifq,
                               input logic [31:0] exc, input logic [31:0] epc,
                               input logic [5:0] eStall, input logic eFlush,
                               input logic [31:0] ePc, input logic eTaken,
                               input logic eWdog, input logic [1:0] eState,
                               input string name);
    ExpectT e;
    rst         = r;
    stallreqMem = mem;
    stallreqEx  = ex;
    stallreqId  = id;
    stallreqIf  = ifq;
    excepttype  = exc;
    cp0Epc      = epc;
    e.stall     = eStall;
    e.flush     = eFlush;
    e.newPc     = ePc;
    e.excTaken  = eTaken;
    e.wdog      = eWdog;
    e.state     = eState;
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input ExpectT e, input string name);
    checks++;
    if (stallOut !== e.stall) begin
      errors++;
      $display("[TB] FAIL %s.stall got %b want %b", name, stallOut, e.stall);
    end
    checks++;
    if (flushOut !== e.flush) begin
      errors++;
      $display("[TB] FAIL %s.flush got %b want %b", name, flushOut, e.flush);
    end
    checks++;
    if (newPcOut !== e.newPc) begin
      errors++;
      $display("[TB] FAIL %s.newPc got %h want %h", name, newPcOut, e.newPc);
    end
    checks++;
    if (excTakenOut !== e.excTaken) begin
      errors++;
      $display("[TB] FAIL %s.excTaken got %b want %b", name, excTakenOut, e.excTaken);
    end
    checks++;
    if (wdogOut !== e.wdog) begin
      errors++;
      $display("[TB] FAIL %s.wdog got %b want %b", name, wdogOut, e.wdog);
    end
    checks++;
    if (stateOut !== e.state) begin
      errors++;
      $display("[TB] FAIL %s.state got %0d want %0d", name, stateOut, e.state);
    end
  endtask

  // Monitor: independent of stimulus, compares whatever expectation is queued.
  initial begin
    ExpectT e;
    string  n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(e, n);
      end
    end
  end

  initial begin
    int waitCycles;
    rst = 1'b1; stallreqMem = 0; stallreqEx = 0; stallreqId = 0; stallreqIf = 0;
    excepttype = '0; cp0Epc = '0;
    repeat (2) @(posedge clk);
    #1;

    //            rst mem ex id if  exc      epc       | stall     fl  newPc     tk wd st
    applyStimulus(1, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "reset");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "idle");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0,   6'b001111, 0, 32'h0,    0, 0, 0, "exStall");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "exRelease");
    applyStimulus(0, 1, 0, 1, 0, 32'h0, 32'h0,     6'b011111, 0, 32'h0,    0, 0, 0, "memWins");
    applyStimulus(0, 0, 0, 1, 0, 32'h0, 32'h0,     6'b000111, 0, 32'h0,    0, 0, 0, "idOnly");
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h0,     6'b000011, 0, 32'h0,    0, 0, 0, "ifOnly");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "quiet");

    applyStimulus(0, 0, 0, 0, 0, 32'h8, 32'h0,     6'b000000, 1, 32'h20,   0, 0, 0, "exc8Flush");
    applyStimulus(0, 0, 0, 0, 0, 32'h8, 32'h0,     6'b000000, 0, 32'h0,    1, 0, 2, "flushHoldStale");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "backToRun");

    applyStimulus(0, 1, 0, 0, 0, 32'hE, 32'h1234,  6'b011111, 0, 32'h0,    0, 0, 0, "eretPend1");
    applyStimulus(0, 1, 0, 0, 0, 32'hE, 32'h1234,  6'b011111, 0, 32'h0,    0, 0, 1, "eretPend2");
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h1234,  6'b011111, 0, 32'h0,    0, 0, 1, "eretPend3");
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h1234,  6'b011111, 0, 32'h0,    0, 0, 1, "eretPend4");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 1, 32'h1234, 0, 0, 1, "eretFlush");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    1, 0, 2, "eretHold");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "eretRun");

    applyStimulus(0, 0, 0, 0, 1, 32'h4, 32'h0,     6'b000000, 1, 32'h20,   0, 0, 0, "ifExcFlush");
    applyStimulus(0, 0, 0, 0, 1, 32'h4, 32'h0,     6'b000011, 0, 32'h0,    1, 0, 3, "ifDrain1");
    applyStimulus(0, 0, 0, 0, 1, 32'h0, 32'h0,     6'b000011, 0, 32'h0,    0, 0, 3, "ifDrain2");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000001, 0, 32'h0,    0, 0, 3, "ifDiscard");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "ifRun");

    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 0, 1, 0, 32'h0, 32'h0,   6'b000111, 0, 32'h0,    0, 0, 0, "wdogCount");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 1, 0, "wdogPulse");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "wdogSingle");

    applyStimulus(0, 1, 0, 0, 0, 32'h8, 32'h0,     6'b011111, 0, 32'h0,    0, 0, 0, "rstPendEnter");
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h0,     6'b011111, 0, 32'h0,    0, 0, 1, "rstPendHold");
    applyStimulus(1, 1, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 1, "rstDuring");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "rstAfter");
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0,     6'b000000, 0, 32'h0,    0, 0, 0, "rstIdle");

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
